// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer placed directly after UART_RX. Each rising edge of
// data_valid captures P_DATA into a small circular FIFO. The oldest word is
// presented show-ahead on a valid/ready read port. The block also reports the
// fill level and raises a sticky overflow flag whenever a byte is dropped.
//
// Parameters
//   DATA_WIDTH  width of a received word (matches P_DATA)
//   DEPTH_LOG2  log2 of the FIFO depth, legal range 1..6
//
// Ports
//   CLK         single clock (UART_RX domain)
//   RST         synchronous active-high reset
//   P_DATA      received word from UART_RX
//   data_valid  byte-valid level from UART_RX; one write per rising edge
//   RD_DATA     oldest stored word (show-ahead); don't-care while RD_VALID=0
//   RD_VALID    FIFO non-empty
//   RD_READY    consumer takes RD_DATA this cycle
//   COUNT       number of stored words, 0..2^DEPTH_LOG2
//   FULL        COUNT == 2^DEPTH_LOG2
//   OVERFLOW    sticky: a received word was dropped
//   OVF_CLR     clears OVERFLOW (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  FULL,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  dv_q;
    logic                  overflow_q;

    logic wr_req;
    logic rd_fire;
    logic wr_accept;
    logic wr_drop;

    // Status decoded from the explicit occupancy register.
    assign COUNT    = count_q;
    assign FULL     = (count_q == FULL_COUNT);
    assign RD_VALID = (count_q != '0);
    assign OVERFLOW = overflow_q;

    // Show-ahead read straight from the register array.
    assign RD_DATA = mem[rd_ptr];

    // One write per rising edge of data_valid, however long the level is held.
    assign wr_req  = data_valid & ~dv_q;
    assign rd_fire = RD_VALID & RD_READY;

    // A full FIFO still accepts a write when a read frees a slot in the same
    // cycle; only without that read is the word dropped.
    assign wr_accept = wr_req & (~FULL | rd_fire);
    assign wr_drop   = wr_req & FULL & ~rd_fire;

    // NOTE: the storage array has no reset; its contents are unreachable until
    // written, because RD_VALID gates every read after the pointers clear.
    always_ff @(posedge CLK) begin
        if (!RST && wr_accept) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Held high through reset so a data_valid level that spans reset
            // release must be seen low before it can write again.
            dv_q       <= 1'b1;
        end else begin
            dv_q <= data_valid;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({wr_accept, rd_fire})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase

            // Set has priority over clear.
            if (wr_drop) begin
                overflow_q <= 1'b1;
            end else if (OVF_CLR) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed self-checking bench for uart_rx_fifo (DATA_WIDTH=8, DEPTH_LOG2=3).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic       RD_READY;
    logic [3:0] COUNT;
    logic       FULL;
    logic       OVERFLOW;
    logic       OVF_CLR;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .OVERFLOW  (OVERFLOW),
        .OVF_CLR   (OVF_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One data_valid pulse (high one cycle, low one cycle), consumer idle.
    task automatic push(input logic [7:0] d);
        P_DATA     = d;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
    endtask

    // Check the head word, then consume it.
    task automatic pop(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(RD_VALID), 32'd1);
        check({tag, "_data"}, 32'(RD_DATA), 32'(exp));
        RD_READY = 1'b1;
        step();
        RD_READY = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        data_valid = 1'b0;
        RD_READY   = 1'b0;
        OVF_CLR    = 1'b0;
        step();
        step();
        RST = 1'b0;

        // Reset state.
        check("rst_valid", 32'(RD_VALID), 32'd0);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        step();  // data_valid seen low after reset

        // Single byte: visible one cycle after the data_valid rise.
        P_DATA     = 8'h46;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        check("single_valid", 32'(RD_VALID), 32'd1);
        check("single_data", 32'(RD_DATA), 32'h46);
        check("single_count", 32'(COUNT), 32'd1);
        RD_READY = 1'b1;
        step();
        RD_READY = 1'b0;
        check("single_rd_valid", 32'(RD_VALID), 32'd0);
        check("single_rd_count", 32'(COUNT), 32'd0);

        // Held level: exactly one write.
        P_DATA     = 8'hA5;
        data_valid = 1'b1;
        repeat (10) step();
        check("held_count", 32'(COUNT), 32'd1);
        check("held_data", 32'(RD_DATA), 32'hA5);

        // Reset with data_valid held high across release: no write.
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        step();
        check("held_rst_count", 32'(COUNT), 32'd0);
        check("held_rst_valid", 32'(RD_VALID), 32'd0);
        data_valid = 1'b0;
        step();

        // Fill to full, then drop one.
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("fill_full", 32'(FULL), 32'd1);
        check("fill_count", 32'(COUNT), 32'd8);
        check("fill_ovf_pre", 32'(OVERFLOW), 32'd0);
        push(8'h09);
        check("drop_ovf", 32'(OVERFLOW), 32'd1);
        check("drop_count", 32'(COUNT), 32'd8);
        for (int i = 1; i <= 8; i++) pop("drain", 8'(i));
        check("drain_empty", 32'(RD_VALID), 32'd0);
        check("drain_count", 32'(COUNT), 32'd0);

        // Offset the pointers so the next four words straddle the wrap.
        for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
        for (int i = 0; i < 6; i++) pop("offset", 8'(8'h20 + i));
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        check("wrap_count", 32'(COUNT), 32'd4);
        for (int i = 0; i < 4; i++) pop("wrap", 8'(8'h10 + i));
        check("wrap_empty", 32'(RD_VALID), 32'd0);

        // Clear the sticky flag on its own.
        OVF_CLR = 1'b1;
        step();
        OVF_CLR = 1'b0;
        check("clr_ovf", 32'(OVERFLOW), 32'd0);

        // Full with simultaneous read and write.
        for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
        check("simul_pre_count", 32'(COUNT), 32'd8);
        check("simul_head", 32'(RD_DATA), 32'h30);
        P_DATA     = 8'h55;
        data_valid = 1'b1;
        RD_READY   = 1'b1;
        step();
        data_valid = 1'b0;
        RD_READY   = 1'b0;
        check("simul_ovf", 32'(OVERFLOW), 32'd0);
        check("simul_count", 32'(COUNT), 32'd8);
        check("simul_full", 32'(FULL), 32'd1);
        step();
        for (int i = 1; i < 8; i++) pop("simul", 8'(8'h30 + i));
        pop("simul_last", 8'h55);
        check("simul_empty", 32'(RD_VALID), 32'd0);

        // Overflow set beats a same-cycle clear; a lone clear then clears.
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        P_DATA     = 8'h99;
        data_valid = 1'b1;
        OVF_CLR    = 1'b1;
        step();
        data_valid = 1'b0;
        check("prio_ovf_set", 32'(OVERFLOW), 32'd1);
        step();
        OVF_CLR = 1'b0;
        check("prio_ovf_clr", 32'(OVERFLOW), 32'd0);
        check("prio_count", 32'(COUNT), 32'd8);

        // Reset mid-stream with three words stored and the flag set.
        push(8'h98);
        check("mid_ovf_pre", 32'(OVERFLOW), 32'd1);
        for (int i = 0; i < 5; i++) pop("mid", 8'(8'h40 + i));
        check("mid_count_pre", 32'(COUNT), 32'd3);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mid_count", 32'(COUNT), 32'd0);
        check("mid_valid", 32'(RD_VALID), 32'd0);
        check("mid_full", 32'(FULL), 32'd0);
        check("mid_ovf", 32'(OVERFLOW), 32'd0);
        step();
        push(8'h46);
        check("post_count", 32'(COUNT), 32'd1);
        pop("post", 8'h46);
        check("post_empty", 32'(RD_VALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of `UART_RX`. It captures each byte presented on `P_DATA` when `data_valid` rises, stores it in a small circular FIFO, and hands it to the system side over a valid/ready interface. It also reports the fill level and raises a sticky overflow flag when a received byte has to be dropped.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of a received word; matches `P_DATA`.
- `DEPTH_LOG2`, 3: log2 of the FIFO depth (8 entries by default); legal range 1..6.

Ports:
- `CLK`  in  1  single clock; the `UART_RX` clock domain.
- `RST`  in  1  synchronous, active-high reset.
- `P_DATA`  in  DATA_WIDTH  received byte from `UART_RX`.
- `data_valid`  in  1  byte-valid from `UART_RX`; a write occurs once per rising edge, regardless of how long the level is held.
- `RD_DATA`  out  DATA_WIDTH  oldest stored word; show-ahead.
- `RD_VALID`  out  1  FIFO non-empty.
- `RD_READY`  in  1  consumer accepts `RD_DATA` this cycle.
- `COUNT`  out  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
- `FULL`  out  1  `COUNT == 2^DEPTH_LOG2`.
- `OVERFLOW`  out  1  sticky flag; a byte was dropped.
- `OVF_CLR`  in  1  clears `OVERFLOW`.

## Operation
- Edge detect: `dv_q` registers `data_valid`. The write request is `wr_req = data_valid & ~dv_q`.
- Read handshake: a read occurs when `rd_fire = RD_VALID & RD_READY`.
- Storage: a register array of 2^DEPTH_LOG2 entries, with a write pointer and a read pointer, each DEPTH_LOG2 bits wide and wrapping modulo depth.
  - `COUNT` is kept as an explicit register.
  - `FULL` and `RD_VALID` (`COUNT != 0`) are decoded from `COUNT`.
- Write accepted when `wr_req & (~FULL | rd_fire)`:
  - `mem[wr_ptr] <= P_DATA`, then `wr_ptr` increments.
- Read:
  - `rd_ptr` increments on `rd_fire`.
  - `RD_DATA = mem[rd_ptr]`, read combinationally from the registered array.
  - `RD_DATA` is don't-care while `RD_VALID` is 0; the bench must not check it then.
- `COUNT` update: +1 on an accepted write with no read; −1 on a read with no write; unchanged when both occur or neither occurs.
- Full with a write request:
  - If `rd_fire` is asserted in the same cycle, the write is accepted (the slot is freed that cycle) and `COUNT` stays at full.
  - Otherwise the byte is dropped, `OVERFLOW <= 1`, and the pointers and contents are unchanged.
- Empty with a write request: the write is accepted. No read is possible that cycle because `RD_VALID` is 0, so there is no write-through bypass.
- `OVERFLOW`: a set and `OVF_CLR` in the same cycle leave it at 1 (set wins). Otherwise `OVF_CLR` clears it.
- Reset, including mid-operation: `wr_ptr`, `rd_ptr`, `COUNT` = 0; `OVERFLOW` = 0; `dv_q` = 1.
  - Resetting `dv_q` to 1 means a `data_valid` level held high across reset release does not create a write; `data_valid` must first be seen low.
  - Array contents are not reset.
  - Reset overrides every other input in that cycle.

## Timing
- All state updates happen on the rising edge of `CLK`. `RST` is sampled only on that edge.
- Output values after reset: `RD_VALID` 0, `COUNT` 0, `FULL` 0, `OVERFLOW` 0, `RD_DATA` don't-care.
- Write latency: with the `data_valid` rise sampled at edge N, the word is stored at edge N. After edge N, `RD_VALID` = 1, `COUNT` has incremented, and `RD_DATA` shows the word if the FIFO was previously empty. This is one cycle from `data_valid` to `RD_VALID`.
- Read: `RD_DATA`/`RD_VALID` are valid before edge M at which `rd_fire` is sampled. The next word, or `RD_VALID` = 0, appears after edge M.
- Throughput: one write per `data_valid` rising edge (at most every 2 cycles) and one read per cycle.
- `OVERFLOW` rises one edge after the dropped request.
- `RD_READY` is allowed to be high while `RD_VALID` is 0; it has no effect.

## Test plan
- **Reset, single byte:** after `RST`, pulse `data_valid` with `P_DATA`=0x46 and `RD_READY`=0 → next cycle `RD_VALID`=1, `RD_DATA`=0x46, `COUNT`=1. Then `RD_READY`=1 for 1 cycle → `RD_VALID`=0, `COUNT`=0.
- **Held level:** hold `data_valid` high for 10 cycles with `P_DATA`=0xA5 → exactly one write, `COUNT`=1. Assert `RST` while `data_valid` is high, then release with `data_valid` still high → `COUNT` stays 0.
- **Fill, overflow, wrap:** write 0x01..0x08, then 0x09 with `RD_READY`=0 → `FULL`=1, `COUNT`=8, `OVERFLOW`=1. Read all → 0x01..0x08 in order, 0x09 absent. Write 0x10..0x13 and read them back → pointer wrap is correct.
- **Full with simultaneous read and write:** at `COUNT`=8, rising `data_valid` with `P_DATA`=0x55 and `RD_READY`=1 in the same cycle → `OVERFLOW` stays 0, `COUNT`=8, and 0x55 is read out last.
- **Overflow clear priority:** assert `OVF_CLR` in the same cycle as a dropped write → `OVERFLOW`=1. Assert `OVF_CLR` alone on the next cycle → `OVERFLOW`=0.
- **Reset mid-stream:** with 3 words stored, assert `RST` for 1 cycle → `COUNT`=0, `RD_VALID`=0, `FULL`=0, `OVERFLOW`=0. The next write of 0x46 reads back as 0x46.
